// File: rtl/control_sequencer.sv
// Hardwired multi-cycle controller for the 8-bit datapath: two-byte fetch, then one or two execute cycles.
// Control outputs decode state and IR directly, so an asynchronous reset releases memory in the same cycle.
module control_sequencer #(
  parameter bit RESET_IDLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir_in,
  input  logic [3:0]  flag_in,
  output logic [1:0]  outasel,
  output logic [1:0]  outbsel,
  output logic [1:0]  funsel_arf,
  output logic [1:0]  funsel_rf,
  output logic [1:0]  funsel_IR,
  output logic [3:0]  regsel_arf,
  output logic [3:0]  regsel_rf,
  output logic [3:0]  rf_tsel,
  output logic [2:0]  rf_o1sel,
  output logic [2:0]  rf_o2sel,
  output logic [3:0]  funsel_alu,
  output logic        IR_enable,
  output logic        IR_lh,
  output logic [1:0]  MUXSelA,
  output logic [1:0]  MUXSelB,
  output logic        MUXSelC,
  output logic        wrMEM,
  output logic        csMEM,
  output logic        halted,
  output logic [2:0]  t_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH_L = 3'b001,
    S_FETCH_H = 3'b010,
    S_EXEC1   = 3'b011,
    S_EXEC2   = 3'b100,
    S_HALT    = 3'b101
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDM = 4'h2;
  localparam logic [3:0] OP_STM = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_BRA = 4'hB;
  localparam logic [3:0] OP_BEQ = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hD;

  function automatic logic [3:0] alu_fun(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_fun = 4'b0100;
      OP_SUB:  alu_fun = 4'b0101;
      OP_AND:  alu_fun = 4'b0111;
      OP_OR:   alu_fun = 4'b1000;
      OP_XOR:  alu_fun = 4'b1010;
      default: alu_fun = 4'b0000;
    endcase
  endfunction

  state_t      r_state;
  logic        r_z;
  logic [3:0]  w_op;
  logic [3:0]  w_dst_en;
  logic [2:0]  w_dst_sel;
  logic [2:0]  w_src_sel;
  logic        w_is_alu;
  logic        w_two_cycle;
  logic        w_unused_bits;

  assign w_op          = ir_in[15:12];
  assign w_dst_en      = 4'b1000 >> ir_in[11:10];
  assign w_dst_sel     = {1'b1, ir_in[11:10]};
  assign w_src_sel     = {1'b1, ir_in[9:8]};
  assign w_is_alu      = (w_op >= OP_ADD) && (w_op <= OP_XOR);
  assign w_two_cycle   = w_is_alu || (w_op == OP_LDM) || (w_op == OP_STM);
  assign w_unused_bits = ^{ir_in[7:0], flag_in[2:0]};
  assign t_state       = r_state;

  // State sequencing and the branch Z flag, sampled only when an ALU result lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_IDLE ? S_IDLE : S_FETCH_L;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH_L;
          else       r_state <= S_IDLE;
        end
        S_FETCH_L: r_state <= S_FETCH_H;
        S_FETCH_H: r_state <= S_EXEC1;
        S_EXEC1: begin
          if (w_op == OP_HLT)   r_state <= S_HALT;
          else if (w_two_cycle) r_state <= S_EXEC2;
          else                  r_state <= S_FETCH_L;
        end
        S_EXEC2: begin
          r_state <= S_FETCH_L;
          if (w_is_alu) r_z <= flag_in[3];
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control decode of the current state and instruction.
  always_comb begin
    outasel    = 2'b00;
    outbsel    = 2'b00;
    funsel_arf = 2'b01;
    funsel_rf  = 2'b01;
    funsel_IR  = 2'b01;
    regsel_arf = 4'b0000;
    regsel_rf  = 4'b0000;
    rf_tsel    = 4'b0000;
    rf_o1sel   = 3'b000;
    rf_o2sel   = 3'b000;
    funsel_alu = 4'b0000;
    IR_enable  = 1'b0;
    IR_lh      = 1'b0;
    MUXSelA    = 2'b00;
    MUXSelB    = 2'b00;
    MUXSelC    = 1'b0;
    wrMEM      = 1'b0;
    csMEM      = 1'b1;
    halted     = 1'b0;
    case (r_state)
      S_FETCH_L, S_FETCH_H: begin
        outbsel    = 2'b11;
        csMEM      = 1'b0;
        IR_enable  = 1'b1;
        IR_lh      = (r_state == S_FETCH_H);
        regsel_arf = 4'b0001;
        funsel_arf = 2'b11;
      end
      S_EXEC1: begin
        case (w_op)
          OP_LDI: begin
            MUXSelA   = 2'b10;
            regsel_rf = w_dst_en;
          end
          OP_LDM, OP_STM: begin
            MUXSelB    = 2'b10;
            regsel_arf = 4'b1000;
            funsel_arf = 2'b01;
            if (w_op == OP_STM) begin
              rf_o1sel   = w_src_sel;
              MUXSelC    = 1'b0;
              funsel_alu = 4'b0000;
            end else begin
              rf_o1sel   = 3'b000;
            end
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            rf_o1sel   = w_dst_sel;
            rf_o2sel   = w_src_sel;
            MUXSelC    = 1'b0;
            funsel_alu = alu_fun(w_op);
          end
          OP_INC, OP_DEC: begin
            regsel_rf = w_dst_en;
            funsel_rf = (w_op == OP_INC) ? 2'b11 : 2'b10;
          end
          OP_BRA, OP_BEQ: begin
            // BEQ falls through as a NOP unless the last ALU result was zero.
            if ((w_op == OP_BRA) || r_z) begin
              MUXSelB    = 2'b10;
              regsel_arf = 4'b0001;
              funsel_arf = 2'b01;
            end else begin
              regsel_arf = 4'b0000;
            end
          end
          default: begin
            regsel_arf = 4'b0000;
          end
        endcase
      end
      S_EXEC2: begin
        case (w_op)
          OP_LDM: begin
            outbsel   = 2'b00;
            csMEM     = 1'b0;
            MUXSelA   = 2'b01;
            regsel_rf = w_dst_en;
          end
          OP_STM: begin
            rf_o1sel   = w_src_sel;
            MUXSelC    = 1'b0;
            funsel_alu = 4'b0000;
            outbsel    = 2'b00;
            csMEM      = 1'b0;
            wrMEM      = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            rf_o1sel   = w_dst_sel;
            rf_o2sel   = w_src_sel;
            MUXSelC    = 1'b0;
            funsel_alu = alu_fun(w_op);
            MUXSelA    = 2'b00;
            regsel_rf  = w_dst_en;
          end
          default: begin
            regsel_rf = 4'b0000;
          end
        endcase
      end
      S_HALT: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: each driven cycle queues the expected control word,
// and a negedge monitor pops and compares it against the DUT outputs.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0] t_state;
    logic       halted;
    logic       csMEM;
    logic       wrMEM;
    logic       MUXSelC;
    logic [1:0] MUXSelB;
    logic [1:0] MUXSelA;
    logic       IR_lh;
    logic       IR_enable;
    logic [3:0] funsel_alu;
    logic [2:0] o2sel;
    logic [2:0] o1sel;
    logic [3:0] tsel;
    logic [3:0] rf_en;
    logic [3:0] arf_en;
    logic [1:0] f_ir;
    logic [1:0] f_rf;
    logic [1:0] f_arf;
    logic [1:0] outb;
    logic [1:0] outa;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] ir_in;
  logic [3:0]  flag_in;
  logic [1:0]  outasel, outbsel, funsel_arf, funsel_rf, funsel_IR;
  logic [3:0]  regsel_arf, regsel_rf, rf_tsel, funsel_alu;
  logic [2:0]  rf_o1sel, rf_o2sel, t_state;
  logic        IR_enable, IR_lh, MUXSelC, wrMEM, csMEM, halted;
  logic [1:0]  MUXSelA, MUXSelB;

  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  bit   z_model;
  ctl_t exp_q[$];

  always #5 clk = ~clk;

  control_sequencer #(.RESET_IDLE(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .ir_in(ir_in), .flag_in(flag_in),
    .outasel(outasel), .outbsel(outbsel), .funsel_arf(funsel_arf), .funsel_rf(funsel_rf),
    .funsel_IR(funsel_IR), .regsel_arf(regsel_arf), .regsel_rf(regsel_rf), .rf_tsel(rf_tsel),
    .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel), .funsel_alu(funsel_alu), .IR_enable(IR_enable),
    .IR_lh(IR_lh), .MUXSelA(MUXSelA), .MUXSelB(MUXSelB), .MUXSelC(MUXSelC), .wrMEM(wrMEM),
    .csMEM(csMEM), .halted(halted), .t_state(t_state)
  );

  function automatic bit is_alu_op(input logic [3:0] op);
    return (op >= 4'd4) && (op <= 4'd8);
  endfunction

  function automatic int exec_cycles(input logic [15:0] ir);
    logic [3:0] op = ir[15:12];
    return (is_alu_op(op) || op == 4'd2 || op == 4'd3) ? 4 : 3;
  endfunction

  // Expected controls for one cycle; ph is the cycle role: 0 idle, 1/2 fetch low/high, 3/4 execute, 5 halt.
  function automatic ctl_t ref_ctl(input int ph, input logic [15:0] ir, input bit z);
    ctl_t       c;
    logic [3:0] op      = ir[15:12];
    logic [3:0] one     = 4'b1000;
    logic [3:0] dst_en  = one >> ir[11:10];
    logic [2:0] dst_sel = {1'b1, ir[11:10]};
    logic [2:0] src_sel = {1'b1, ir[9:8]};
    logic [3:0] alu_tab [5] = '{4'b0100, 4'b0101, 4'b0111, 4'b1000, 4'b1010};
    c       = '0;
    c.csMEM = 1'b1;
    c.f_arf = 2'b01;
    c.f_rf  = 2'b01;
    c.f_ir  = 2'b01;
    c.t_state = 3'(ph);
    if (ph == 1 || ph == 2) begin
      c.outb = 2'b11; c.csMEM = 1'b0; c.IR_enable = 1'b1; c.IR_lh = (ph == 2);
      c.arf_en = 4'b0001; c.f_arf = 2'b11;
    end else if (ph == 3) begin
      if (op == 4'd1) begin c.MUXSelA = 2'b10; c.rf_en = dst_en; end
      if (op == 4'd2 || op == 4'd3) begin c.MUXSelB = 2'b10; c.arf_en = 4'b1000; end
      if (op == 4'd3) c.o1sel = src_sel;
      if (is_alu_op(op)) begin c.o1sel = dst_sel; c.o2sel = src_sel; c.funsel_alu = alu_tab[op - 4'd4]; end
      if (op == 4'd9)  begin c.rf_en = dst_en; c.f_rf = 2'b11; end
      if (op == 4'd10) begin c.rf_en = dst_en; c.f_rf = 2'b10; end
      if (op == 4'd11 || (op == 4'd12 && z)) begin c.MUXSelB = 2'b10; c.arf_en = 4'b0001; end
    end else if (ph == 4) begin
      if (op == 4'd2) begin c.csMEM = 1'b0; c.MUXSelA = 2'b01; c.rf_en = dst_en; end
      if (op == 4'd3) begin c.o1sel = src_sel; c.csMEM = 1'b0; c.wrMEM = 1'b1; end
      if (is_alu_op(op)) begin
        c.o1sel = dst_sel; c.o2sel = src_sel; c.funsel_alu = alu_tab[op - 4'd4]; c.rf_en = dst_en;
      end
    end else if (ph == 5) begin
      c.halted = 1'b1;
    end
    return c;
  endfunction

  // Drive one cycle: zf/st < 0 means random Z flag / start.
  task automatic cyc(input int ph, input logic [15:0] ir, input int zf, input int st);
    bit z_next;
    ir_in   = (ph == 3 || ph == 4) ? ir : 16'($urandom);
    flag_in = 4'($urandom);
    if (zf >= 0) flag_in[3] = zf[0];
    start   = (st >= 0) ? st[0] : 1'($urandom);
    exp_q.push_back(ref_ctl(ph, ir, z_model));
    z_next = z_model;
    if (ph == 4 && is_alu_op(ir[15:12])) z_next = flag_in[3];
    @(posedge clk); #1;
    z_model = z_next;
  endtask

  task automatic instr(input logic [15:0] ir, input int zf);
    int last = exec_cycles(ir);
    for (int p = 1; p <= last; p++) cyc(p, ir, zf, -1);
  endtask

  // Monitor: compare the DUT control word against the oldest expectation, away from the active edge.
  always @(negedge clk) begin
    ctl_t act, exp_c;
    ncyc++;
    if (exp_q.size() > 0) begin
      exp_c = exp_q.pop_front();
      act = '{t_state: t_state, halted: halted, csMEM: csMEM, wrMEM: wrMEM, MUXSelC: MUXSelC,
              MUXSelB: MUXSelB, MUXSelA: MUXSelA, IR_lh: IR_lh, IR_enable: IR_enable,
              funsel_alu: funsel_alu, o2sel: rf_o2sel, o1sel: rf_o1sel, tsel: rf_tsel,
              rf_en: regsel_rf, arf_en: regsel_arf, f_ir: funsel_IR, f_rf: funsel_rf,
              f_arf: funsel_arf, outb: outbsel, outa: outasel};
      checks++;
      if (act !== exp_c) begin
        errors++;
        $display("FAIL ctl cycle %0d t_state %0d: actual %h required %h", ncyc, t_state, act, exp_c);
      end
    end
  end

  initial begin
    logic [3:0] op;
    rst = 1'b1; start = 1'b0; ir_in = 16'h0000; flag_in = 4'h0; z_model = 1'b0;
    @(posedge clk); #1;
    repeat (3) cyc(0, 16'h0000, -1, -1);
    rst = 1'b0;
    cyc(0, 16'h0000, -1, 0);
    cyc(0, 16'h0000, -1, 0);
    cyc(0, 16'h0000, -1, 1);

    instr(16'h142A, -1);          // LDI R2,#0x2A
    instr(16'h2080, -1);          // LDM R1,[0x80]
    instr(16'h3090, -1);          // STM R1,[0x90]
    instr(16'h5100, 1);           // SUB R1,R2 -> zero
    instr(16'hC040, -1);          // BEQ taken
    instr(16'h5100, 0);           // SUB non-zero
    instr(16'hC040, -1);          // BEQ not taken
    instr(16'h9800, -1);          // INC R3
    instr(16'hC012, -1);          // BEQ after INC: Z unchanged
    instr(16'hB0FF, -1);          // BRA

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      if (op == 4'hD) op = 4'h0;
      instr({op, 12'($urandom)}, -1);
    end

    instr(16'h4A00, 1);           // ADD with zero result sets Z
    instr(16'hC020, -1);          // BEQ taken
    cyc(1, 16'h3290, -1, -1);
    cyc(2, 16'h3290, -1, -1);
    cyc(3, 16'h3290, -1, -1);
    rst = 1'b1;                   // reset lands in STM EXEC2
    z_model = 1'b0;
    cyc(0, 16'h3290, -1, -1);
    cyc(0, 16'h0000, -1, -1);
    rst = 1'b0;
    cyc(0, 16'h0000, -1, 1);
    instr(16'hC030, -1);          // BEQ not taken: Z cleared by reset

    instr(16'hD000, -1);          // HLT
    repeat (10) cyc(5, 16'h0000, -1, -1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired multi-cycle control unit for the 8-bit datapath (ARF, IR, Memory, register file, ALU, muxes A/B/C).
- Fetches a 16-bit instruction from memory as two bytes at PC, then decodes and executes it in one or two further cycles.
- Drives every control input of the datapath and keeps its own latched Z flag for conditional branches.

Parameters:
RESET_IDLE, 1, 1 = wait in IDLE for start after reset; 0 = go straight to FETCH_L

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  leaves IDLE when high
ir_in  in  16  IR contents: [15:12] opcode, [11:10] dst Rn, [9:8] src Rn, [7:0] imm/addr
flag_in  in  4  ALU flags; bit3 = Z
outasel, outbsel  out  2 each  ARF output selects (00 AR, 01 SP, 10 PCP, 11 PC)
funsel_arf, funsel_rf, funsel_IR  out  2 each  00 clr, 01 load, 10 dec, 11 inc
regsel_arf  out  4  ARF enables {AR, SP, PCP, PC}
regsel_rf, rf_tsel  out  4 each  RF enables {R1..R4} and {T1..T4}
rf_o1sel, rf_o2sel  out  3 each  RF read selects; R1..R4 = 100..111
funsel_alu  out  4  ALU function
IR_enable, IR_lh  out  1 each  IR load enable; byte select (0 = low byte)
MUXSelA, MUXSelB  out  2 each  00 ALU, 01 MEM, 10 IR[7:0], 11 ARF outa
MUXSelC  out  1  0 = rf_o1, 1 = ARF outa
wrMEM, csMEM  out  1 each  memory write (1 = write); chip select (active low)
halted  out  1  high in HALT
t_state  out  3  state code, for debug

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Reset forces state IDLE (or FETCH_L if RESET_IDLE=0) and z_reg=0.
- Outputs are a combinational decode of state and ir_in.
- Defaults, which are also the reset values: all enables 0; rf_tsel=0; csMEM=1; wrMEM=0; funsels 01; funsel_alu=0000; all selects 0; halted=0.
- State codes: IDLE 000, FETCH_L 001, FETCH_H 010, EXEC1 011, EXEC2 100, HALT 101.
- Register decode: dst n gives regsel_rf one-hot (00→1000 … 11→0001) and o1sel 1nn. src n gives o2sel or o1sel 1nn.
- IDLE: defaults. Goes to FETCH_L when start=1.
- FETCH_L: outbsel=11, csMEM=0, IR_enable=1, funsel_IR=01, IR_lh=0, regsel_arf=0001, funsel_arf=11 (PC++). Goes to FETCH_H.
- FETCH_H: same as FETCH_L but IR_lh=1. Goes to EXEC1.
- EXEC1, by opcode:
  - 0000 NOP: no controls.
  - 0001 LDI: MUXSelA=10, load dst.
  - 0010 LDM and 0011 STM: MUXSelB=10, regsel_arf=1000, funsel_arf=01 (AR←imm). STM also sets MUXSelC=0, o1sel=src, funsel_alu=0000.
  - 0100 ADD, 0101 SUB, 0110 AND, 0111 OR, 1000 XOR: o1sel=dst, o2sel=src, MUXSelC=0, funsel_alu = 0100/0101/0111/1000/1010 respectively.
  - 1001 INC and 1010 DEC: load dst with funsel_rf=11 or 10.
  - 1011 BRA: MUXSelB=10, regsel_arf=0001, funsel_arf=01.
  - 1100 BEQ: same as BRA only if z_reg=1, otherwise no controls.
  - 1101 HLT: goes to HALT.
  - 1110 and 1111: NOP.
- EXEC1 next state: EXEC2 for LDM, STM and the ALU ops; otherwise FETCH_L.
- EXEC2 (ALU is registered, so its result is valid here):
  - LDM: outbsel=00, csMEM=0, MUXSelA=01, load dst.
  - STM: ALU selects held from EXEC1; outbsel=00, csMEM=0, wrMEM=1.
  - ALU ops: ALU selects held from EXEC1; MUXSelA=00, load dst; z_reg←flag_in[3] at this edge.
  - Always goes to FETCH_L.
- HALT: defaults, halted=1. Left only by rst.
- Z handling: z_reg is written only in EXEC2 of ALU ops. ALU flag activity in any other cycle is ignored.
- Rst asserted mid-EXEC2 of STM drops wrMEM and raises csMEM immediately; the write is not performed.
- start is ignored outside IDLE.
- PC wrap 0xFF→0x00 is allowed; the controller does not detect it.
- Latency: 3 cycles for NOP, LDI, INC, DEC, BRA, BEQ; 4 cycles for LDM, STM and the ALU ops.

Test Plan:
- LDI: reset, PC=0, MEM[0]=0x2A, MEM[1]=0x14 (LDI R2,#0x2A), start pulse → t_state 001,010,011; R2=0x2A; PC=2; back in 001.
- LDM then STM: MEM[0x80]=0x5C; LDM R1,[0x80] then STM R1,[0x90] → AR=0x90; wrMEM=1 only in the second instruction's EXEC2; MEM[0x90]=0x5C.
- SUB with Z: R1=R2=0x33; SUB R1,R2 then BEQ 0x40 → R1=0x00, z_reg=1, PC=0x40 after BEQ EXEC1. Repeat with R2=0x01 → branch not taken, PC=next.
- INC wrap: R3=0xFF; INC R3 → R3=0x00 after 3 cycles; z_reg unchanged.
- HLT: HLT executes → halted=1, all enables 0, csMEM=1 for 10 cycles; start ignored.
- Reset mid-store: assert rst during STM EXEC2 → same-cycle csMEM=1, wrMEM=0; MEM unchanged; t_state=000.
